// File: rtl/board_scan.sv
// board_scan: walks every board RAM cell in row-major order and hands occupied
// cells to a tile drawer, with a per-cell draw timeout.
module board_scan #(
    parameter int NUM_COLS = 10,
    parameter int NUM_ROWS = 10,
    parameter int TIMEOUT  = 255
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    output logic [7:0] ram_addr,
    input  logic [7:0] ram_data,
    output logic [7:0] cell_addr,
    output logic [7:0] cell_data,
    output logic       cell_valid,
    input  logic       draw_done,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err
);
    typedef enum logic [2:0] {IDLE, READ, LATCH, DRAW, NEXT} state_t;
    state_t     state_q, state_d;
    logic [3:0] row_q, row_d, col_q, col_d;
    logic [7:0] cnt_q, cnt_d, cell_addr_q, cell_addr_d, cell_data_q, cell_data_d;
    logic       frame_done_q, frame_done_d, err_q, err_d;
    logic       last_col, last_row;
    assign last_col    = col_q == 4'(NUM_COLS - 1);
    assign last_row    = row_q == 4'(NUM_ROWS - 1);
    // row/col return to 0 after the last cell, so ram_addr only ever shows in-range cells
    assign ram_addr    = {row_q, col_q};
    assign cell_addr   = cell_addr_q;
    assign cell_data   = cell_data_q;
    assign cell_valid  = state_q == DRAW;
    assign busy        = state_q != IDLE;
    assign frame_done  = frame_done_q;
    assign timeout_err = err_q;
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        cnt_d        = cnt_q;
        cell_addr_d  = cell_addr_q;
        cell_data_d  = cell_data_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = READ;
                row_d   = 4'd0;
                col_d   = 4'd0;
            end
            READ: state_d = LATCH;
            LATCH: begin
                cell_addr_d = {row_q, col_q};
                cell_data_d = ram_data;
                cnt_d       = 8'd0;
                state_d     = ram_data == 8'h00 ? NEXT : DRAW;
            end
            DRAW: begin
                cnt_d = cnt_q + 8'd1;
                // a completion in the timeout cycle wins over the error
                if (draw_done) state_d = NEXT;
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = NEXT;
                    err_d   = 1'b1;
                end
            end
            NEXT: begin
                state_d = last_col && last_row ? IDLE : READ;
                col_d   = last_col ? 4'd0 : col_q + 4'd1;
                row_d   = !last_col ? row_q : last_row ? 4'd0 : row_q + 4'd1;
                frame_done_d = last_col && last_row;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= IDLE;
            row_q        <= 4'd0;
            col_q        <= 4'd0;
            cnt_q        <= 8'd0;
            cell_addr_q  <= 8'd0;
            cell_data_q  <= 8'd0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
            cell_addr_q  <= cell_addr_d;
            cell_data_q  <= cell_data_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end
endmodule
